// File: rtl/mem_arbiter_if.sv
// Signal bundle between the IFU/LSU requesters, the mem_arbiter and the shared
// memory port. The slave modport is the arbiter's view; master is the environment.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req_valid_i;
    logic                  if_req_ready_o;
    logic [ADDR_W-1:0]     if_req_addr_i;
    logic                  if_rsp_valid_o;
    logic                  if_rsp_ready_i;
    logic [DATA_W-1:0]     if_rsp_data_o;
    logic                  if_rsp_err_o;

    logic                  ls_req_valid_i;
    logic                  ls_req_ready_o;
    logic [ADDR_W-1:0]     ls_req_addr_i;
    logic                  ls_req_wen_i;
    logic [DATA_W-1:0]     ls_req_wdata_i;
    logic [DATA_W/8-1:0]   ls_req_wstrb_i;
    logic                  ls_rsp_valid_o;
    logic                  ls_rsp_ready_i;
    logic [DATA_W-1:0]     ls_rsp_data_o;
    logic                  ls_rsp_err_o;

    logic                  m_req_valid_o;
    logic                  m_req_ready_i;
    logic [ADDR_W-1:0]     m_req_addr_o;
    logic                  m_req_wen_o;
    logic [DATA_W-1:0]     m_req_wdata_o;
    logic [DATA_W/8-1:0]   m_req_wstrb_o;
    logic                  m_rsp_valid_i;
    logic                  m_rsp_ready_o;
    logic [DATA_W-1:0]     m_rsp_data_i;

    modport slave (
        input  if_req_valid_i, if_req_addr_i, if_rsp_ready_i,
        output if_req_ready_o, if_rsp_valid_o, if_rsp_data_o, if_rsp_err_o,
        input  ls_req_valid_i, ls_req_addr_i, ls_req_wen_i, ls_req_wdata_i,
               ls_req_wstrb_i, ls_rsp_ready_i,
        output ls_req_ready_o, ls_rsp_valid_o, ls_rsp_data_o, ls_rsp_err_o,
        input  m_req_ready_i, m_rsp_valid_i, m_rsp_data_i,
        output m_req_valid_o, m_req_addr_o, m_req_wen_o, m_req_wdata_o,
               m_req_wstrb_o, m_rsp_ready_o
    );

    modport master (
        output if_req_valid_i, if_req_addr_i, if_rsp_ready_i,
        input  if_req_ready_o, if_rsp_valid_o, if_rsp_data_o, if_rsp_err_o,
        output ls_req_valid_i, ls_req_addr_i, ls_req_wen_i, ls_req_wdata_i,
               ls_req_wstrb_i, ls_rsp_ready_i,
        input  ls_req_ready_o, ls_rsp_valid_o, ls_rsp_data_o, ls_rsp_err_o,
        output m_req_ready_i, m_rsp_valid_i, m_rsp_data_i,
        input  m_req_valid_o, m_req_addr_o, m_req_wen_o, m_req_wdata_o,
               m_req_wstrb_o, m_rsp_ready_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin IFU/LSU arbiter onto one memory port, one transaction in flight,
// with a response timeout that returns an error instead of hanging the requester.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    mem_arbiter_if.slave    bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    typedef enum logic [2:0] {IDLE, REQ, RESP, ERR, DRAIN} state_t;

    state_t           state_q;
    logic             owner_q;
    logic             last_q;
    logic             wen_q;
    logic             swallowed_q;
    logic [CNT_W-1:0] cnt_q;

    logic own_req_valid, own_rsp_ready, req_fire, rsp_fire, any_req, grant_ls;

    always_comb begin
        own_req_valid = (owner_q == OWN_LS) ? bus.ls_req_valid_i : bus.if_req_valid_i;
        own_rsp_ready = (owner_q == OWN_LS) ? bus.ls_rsp_ready_i : bus.if_rsp_ready_i;
        req_fire      = (state_q == REQ) && own_req_valid && bus.m_req_ready_i;
        rsp_fire      = (state_q == RESP) && bus.m_rsp_valid_i && own_rsp_ready;
        any_req       = bus.if_req_valid_i || bus.ls_req_valid_i;
        // On a tie the unit that did not win last time is served.
        grant_ls      = bus.ls_req_valid_i && (!bus.if_req_valid_i || last_q == OWN_IF);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            last_q      <= OWN_LS;
            wen_q       <= 1'b0;
            swallowed_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (any_req) begin
                    owner_q <= grant_ls;
                    last_q  <= grant_ls;
                    state_q <= REQ;
                end
                REQ: if (req_fire) begin
                    state_q <= RESP;
                    cnt_q   <= '0;
                    wen_q   <= (owner_q == OWN_LS) && bus.ls_req_wen_i;
                end
                RESP: begin
                    if (rsp_fire) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_MAX && !bus.m_rsp_valid_i) begin
                        state_q     <= ERR;
                        swallowed_q <= 1'b0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                // A late response landing during ERR means nothing is left to drain.
                ERR: begin
                    if (own_rsp_ready)
                        state_q <= (swallowed_q || bus.m_rsp_valid_i) ? IDLE : DRAIN;
                    else if (bus.m_rsp_valid_i)
                        swallowed_q <= 1'b1;
                end
                DRAIN: if (bus.m_rsp_valid_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.if_req_ready_o = 1'b0;
        bus.ls_req_ready_o = 1'b0;
        bus.if_rsp_valid_o = 1'b0;
        bus.if_rsp_data_o  = {DATA_W{1'b0}};
        bus.if_rsp_err_o   = 1'b0;
        bus.ls_rsp_valid_o = 1'b0;
        bus.ls_rsp_data_o  = {DATA_W{1'b0}};
        bus.ls_rsp_err_o   = 1'b0;
        bus.m_req_valid_o  = 1'b0;
        bus.m_req_addr_o   = {ADDR_W{1'b0}};
        bus.m_req_wen_o    = 1'b0;
        bus.m_req_wdata_o  = {DATA_W{1'b0}};
        bus.m_req_wstrb_o  = {STRB_W{1'b0}};
        bus.m_rsp_ready_o  = 1'b0;
        case (state_q)
            REQ: begin
                bus.m_req_valid_o = own_req_valid;
                if (owner_q == OWN_LS) begin
                    bus.m_req_addr_o   = bus.ls_req_addr_i;
                    bus.m_req_wen_o    = bus.ls_req_wen_i;
                    bus.m_req_wdata_o  = bus.ls_req_wdata_i;
                    bus.m_req_wstrb_o  = bus.ls_req_wstrb_i;
                    bus.ls_req_ready_o = bus.m_req_ready_i;
                end else begin
                    bus.m_req_addr_o   = bus.if_req_addr_i;
                    bus.if_req_ready_o = bus.m_req_ready_i;
                end
            end
            RESP: begin
                bus.m_rsp_ready_o = own_rsp_ready;
                if (owner_q == OWN_LS) begin
                    bus.ls_rsp_valid_o = bus.m_rsp_valid_i;
                    bus.ls_rsp_data_o  = wen_q ? {DATA_W{1'b0}} : bus.m_rsp_data_i;
                end else begin
                    bus.if_rsp_valid_o = bus.m_rsp_valid_i;
                    bus.if_rsp_data_o  = bus.m_rsp_data_i;
                end
            end
            ERR: begin
                bus.m_rsp_ready_o = 1'b1;
                if (owner_q == OWN_LS) begin
                    bus.ls_rsp_valid_o = 1'b1;
                    bus.ls_rsp_err_o   = 1'b1;
                end else begin
                    bus.if_rsp_valid_o = 1'b1;
                    bus.if_rsp_err_o   = 1'b1;
                end
            end
            DRAIN: bus.m_rsp_ready_o = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected downstream requests and unit responses
// are queued by the stimulus and consumed by a negedge monitor.
module tb_mem_arbiter;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        bit          unit;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        bit          unit;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_req(input bit unit, input logic [31:0] addr, input logic wen,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        req_t r;
        r.unit = unit; r.addr = addr; r.wen = wen; r.wdata = wdata; r.wstrb = wstrb;
        exp_req.push_back(r);
    endtask

    task automatic push_rsp(input bit unit, input logic [31:0] data, input logic err);
        rsp_t r;
        r.unit = unit; r.data = data; r.err = err;
        exp_rsp.push_back(r);
    endtask

    function automatic bit hs(input int which);
        case (which)
            0: return bus.if_req_valid_i && bus.if_req_ready_o;
            1: return bus.ls_req_valid_i && bus.ls_req_ready_o;
            2: return bus.m_req_valid_o && bus.m_req_ready_i;
            3: return bus.m_rsp_valid_i && bus.m_rsp_ready_o;
            4: return bus.if_rsp_valid_o && bus.if_rsp_ready_i;
            default: return bus.ls_rsp_valid_o && bus.ls_rsp_ready_i;
        endcase
    endfunction

    // Returns 1ns after the clock edge that completes the handshake.
    task automatic wait_hs(input int which, input string name);
        int n = 0;
        @(negedge clk);
        while (!hs(which) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!hs(which)) begin
            checks++;
            errors++;
            $display("FAIL %s: no handshake within 200 cycles", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input bit unit, input logic [31:0] addr, input logic wen,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        if (!unit) begin
            bus.if_req_valid_i = 1'b1;
            bus.if_req_addr_i  = addr;
            wait_hs(0, "if_req");
            bus.if_req_valid_i = 1'b0;
            bus.if_req_addr_i  = '0;
        end else begin
            bus.ls_req_valid_i = 1'b1;
            bus.ls_req_addr_i  = addr;
            bus.ls_req_wen_i   = wen;
            bus.ls_req_wdata_i = wdata;
            bus.ls_req_wstrb_i = wstrb;
            wait_hs(1, "ls_req");
            bus.ls_req_valid_i = 1'b0;
            bus.ls_req_addr_i  = '0;
            bus.ls_req_wen_i   = 1'b0;
            bus.ls_req_wdata_i = '0;
            bus.ls_req_wstrb_i = '0;
        end
    endtask

    task automatic do_txn(input bit unit, input logic [31:0] addr, input logic wen,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
        send_req(unit, addr, wen, wdata, wstrb);
        wait_hs(unit ? 5 : 4, unit ? "ls_rsp" : "if_rsp");
    endtask

    // Downstream slave: holds ready low for `stall` cycles of a valid request,
    // then answers `delay` cycles into RESP unless muted.
    task automatic slave_txn(input int stall, input int delay, input logic [31:0] data,
                             input bit mute);
        bus.m_req_ready_i = (stall == 0);
        if (stall != 0) begin
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (bus.m_req_valid_o) break;
            end
            repeat (stall) @(posedge clk);
            #1;
            bus.m_req_ready_i = 1'b1;
        end
        wait_hs(2, "m_req");
        bus.m_req_ready_i = 1'b0;
        repeat (delay) begin
            @(posedge clk);
            #1;
        end
        if (!mute) begin
            bus.m_rsp_valid_i = 1'b1;
            bus.m_rsp_data_i  = data;
            wait_hs(3, "m_rsp");
            bus.m_rsp_valid_i = 1'b0;
            bus.m_rsp_data_i  = '0;
        end
    endtask

    task automatic chk_quiet(input string name);
        chk(name, {bus.if_req_ready_o, bus.ls_req_ready_o, bus.m_req_valid_o,
                   bus.m_rsp_ready_o, bus.if_rsp_valid_o, bus.ls_rsp_valid_o,
                   bus.if_rsp_err_o, bus.ls_rsp_err_o, bus.m_req_wen_o}, 64'd0);
    endtask

    task automatic check_rsp(input bit unit, input logic [31:0] data, input logic err);
        rsp_t e;
        if (exp_rsp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: unit %0d data %0h err %0d, none expected", unit, data, err);
        end else begin
            e = exp_rsp.pop_front();
            chk("rsp_unit", {63'd0, unit}, {63'd0, e.unit});
            chk("rsp_data", data, e.data);
            chk("rsp_err", err, e.err);
        end
    endtask

    always @(negedge clk) begin
        req_t e;
        if (rst_n) begin
            if (hs(2)) begin
                if (exp_req.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: addr %0h, none expected", bus.m_req_addr_o);
                end else begin
                    e = exp_req.pop_front();
                    chk("req_unit", bus.ls_req_ready_o, e.unit);
                    chk("req_addr", bus.m_req_addr_o, e.addr);
                    chk("req_wen", bus.m_req_wen_o, e.wen);
                    chk("req_wdata", bus.m_req_wdata_o, e.wdata);
                    chk("req_wstrb", bus.m_req_wstrb_o, e.wstrb);
                end
            end
            if (hs(4)) check_rsp(1'b0, bus.if_rsp_data_o, bus.if_rsp_err_o);
            if (hs(5)) check_rsp(1'b1, bus.ls_rsp_data_o, bus.ls_rsp_err_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.if_req_valid_i = 1'b1;
        bus.if_req_addr_i  = 32'h1234;
        bus.if_rsp_ready_i = 1'b1;
        bus.ls_req_valid_i = 1'b1;
        bus.ls_req_addr_i  = 32'h5678;
        bus.ls_req_wen_i   = 1'b1;
        bus.ls_req_wdata_i = '0;
        bus.ls_req_wstrb_i = '0;
        bus.ls_rsp_ready_i = 1'b1;
        bus.m_req_ready_i  = 1'b1;
        bus.m_rsp_valid_i  = 1'b1;
        bus.m_rsp_data_i   = '0;

        // Reset: outputs stay quiet even with every input active.
        @(negedge clk);
        chk_quiet("reset_outputs");
        chk("reset_addr", bus.m_req_addr_o, 0);
        bus.if_req_valid_i = 1'b0;
        bus.if_req_addr_i  = '0;
        bus.ls_req_valid_i = 1'b0;
        bus.ls_req_addr_i  = '0;
        bus.ls_req_wen_i   = 1'b0;
        bus.m_req_ready_i  = 1'b0;
        bus.m_rsp_valid_i  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_quiet("post_reset_idle");
        @(posedge clk);
        #1;

        // IFU-only read, response two cycles into RESP.
        push_req(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0);
        push_rsp(1'b0, 32'h0000_0013, 1'b0);
        fork
            do_txn(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0);
            slave_txn(0, 2, 32'h0000_0013, 1'b0);
            begin
                int ls_rdy = 0;
                @(negedge clk);
                chk("latency_idle_cycle", bus.m_req_valid_o, 0);
                @(negedge clk);
                chk("latency_req_cycle", bus.m_req_valid_o, 1);
                for (int i = 0; i < 6; i++) begin
                    if (bus.ls_req_ready_o) ls_rdy++;
                    @(negedge clk);
                end
                chk("ifu_only_ls_ready", ls_rdy, 0);
            end
        join

        // LSU write: write responses carry zero data whatever the slave returns.
        push_req(1'b1, 32'h0000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
        push_rsp(1'b1, 32'h0, 1'b0);
        fork
            do_txn(1'b1, 32'h0000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
            slave_txn(0, 0, 32'hFFFF_FFFF, 1'b0);
        join

        // Timeout: count 0..TO spans TO+1 RESP cycles, the error shows on the next.
        push_req(1'b1, 32'h0000_2000, 1'b0, 32'h0, 4'h0);
        push_rsp(1'b1, 32'h0, 1'b1);
        fork
            do_txn(1'b1, 32'h0000_2000, 1'b0, 32'h0, 4'h0);
            slave_txn(0, 0, 32'h0, 1'b1);
            begin
                int k = 0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (hs(2)) break;
                end
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    k++;
                    if (bus.ls_rsp_valid_o) break;
                end
                chk("timeout_err_cycle", k, TO + 2);
            end
        join
        repeat (2) @(posedge clk);
        #1;
        bus.m_rsp_valid_i = 1'b1;
        bus.m_rsp_data_i  = 32'h0000_0BAD;
        @(negedge clk);
        chk("drain_m_rsp_ready", bus.m_rsp_ready_o, 1);
        chk("drain_not_forwarded", {bus.if_rsp_valid_o, bus.ls_rsp_valid_o}, 0);
        @(posedge clk);
        #1;
        bus.m_rsp_valid_i = 1'b0;
        bus.m_rsp_data_i  = '0;
        push_req(1'b0, 32'h8000_0004, 1'b0, 32'h0, 4'h0);
        push_rsp(1'b0, 32'h0000_0017, 1'b0);
        fork
            do_txn(1'b0, 32'h8000_0004, 1'b0, 32'h0, 4'h0);
            slave_txn(0, 1, 32'h0000_0017, 1'b0);
        join

        // Backpressure: 10 stalled REQ cycles, then requester holds rsp_ready low 3 cycles.
        push_req(1'b1, 32'h0000_3000, 1'b0, 32'h0, 4'h0);
        push_rsp(1'b1, 32'hCAFE_F00D, 1'b0);
        bus.ls_rsp_ready_i = 1'b0;
        fork
            send_req(1'b1, 32'h0000_3000, 1'b0, 32'h0, 4'h0);
            slave_txn(10, 0, 32'hCAFE_F00D, 1'b0);
            begin
                int stalled = 0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (hs(2)) break;
                    if (bus.m_req_valid_o && bus.m_req_addr_o == 32'h3000) stalled++;
                end
                chk("bp_stall_cycles", stalled, 10);
            end
            begin
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (bus.m_rsp_valid_i) break;
                end
                for (int i = 0; i < 3; i++) begin
                    if (i > 0) @(negedge clk);
                    chk("bp_m_rsp_ready_low", bus.m_rsp_ready_o, 0);
                    chk("bp_ls_rsp_valid", bus.ls_rsp_valid_o, 1);
                end
                @(posedge clk);
                #1;
                bus.ls_rsp_ready_i = 1'b1;
                @(negedge clk);
                chk("bp_m_rsp_ready_high", bus.m_rsp_ready_o, 1);
            end
        join

        // Reset in RESP, then four tied rounds must alternate starting with IF.
        push_req(1'b0, 32'h0000_4000, 1'b0, 32'h0, 4'h0);
        fork
            send_req(1'b0, 32'h0000_4000, 1'b0, 32'h0, 4'h0);
            slave_txn(0, 0, 32'h0, 1'b1);
        join
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("resp_m_rsp_ready_before_reset", bus.m_rsp_ready_o, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_quiet("async_reset_outputs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        push_req(1'b0, 32'h0000_0100, 1'b0, 32'h0, 4'h0);
        push_req(1'b1, 32'h0000_0200, 1'b0, 32'h0, 4'h0);
        push_req(1'b0, 32'h0000_0104, 1'b0, 32'h0, 4'h0);
        push_req(1'b1, 32'h0000_0204, 1'b0, 32'h0, 4'h0);
        push_rsp(1'b0, 32'h0000_00A0, 1'b0);
        push_rsp(1'b1, 32'h0000_00A1, 1'b0);
        push_rsp(1'b0, 32'h0000_00A2, 1'b0);
        push_rsp(1'b1, 32'h0000_00A3, 1'b0);
        fork
            begin
                do_txn(1'b0, 32'h0000_0100, 1'b0, 32'h0, 4'h0);
                do_txn(1'b0, 32'h0000_0104, 1'b0, 32'h0, 4'h0);
            end
            begin
                do_txn(1'b1, 32'h0000_0200, 1'b0, 32'h0, 4'h0);
                do_txn(1'b1, 32'h0000_0204, 1'b0, 32'h0, 4'h0);
            end
            for (int k = 0; k < 4; k++) slave_txn(0, 1, 32'h0000_00A0 + k, 1'b0);
        join

        repeat (3) @(posedge clk);
        chk("exp_req_drained", exp_req.size(), 0);
        chk("exp_rsp_drained", exp_rsp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
